daa_mac_pe: RTL and testbench
=============================

Name: daa_mac_pe

Overview:
Parametrised neuron processing element with a dynamic-alignment accumulator.
- Serially multiplies an activation by a signed weight, one radix-4 Booth digit per cycle.
- Accumulates the products into an ACC_W-bit accumulator that rescales itself on overflow: it shifts right and increments a shared exponent, and saturates once the exponent is exhausted.
- Sits between the activation/weight feeder and the neuron output stage.
- Uses valid/ready handshakes on both sides. An epoch ends on a `last`-tagged beat, which emits {acc, exp, sat}.

Parameters:
- IN_W, 4, activation width (unsigned, or two's complement when in_signed=1).
- W_W, 4, weight width; two's complement, must be even. Booth digit count ND = W_W/2.
- ACC_W, 12, accumulator width; must be ≥ IN_W+1+W_W.
- EXP_W, 3, exponent width; EXP_MAX = 2^EXP_W − 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  PE can accept a beat.
- in_x  in  IN_W  activation.
- in_signed  in  1  1: in_x is sign-extended; 0: in_x is zero-extended, to IN_W+1 bits.
- in_w  in  W_W  weight (signed).
- in_last  in  1  final beat of the epoch.
- acc_clr  in  1  synchronous clear of acc/exp/sat.
- out_valid  out  1  epoch result valid.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_W  accumulator (signed).
- out_exp  out  EXP_W  scale exponent; true value = out_acc·2^out_exp.
- out_sat  out  1  sticky saturation flag.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; acc=0, exp=0, sat=0, product register P=0.
  - out_valid=0, busy=0, in_ready=0 while rst is high.
  - Reset mid-operation abandons the beat and any pending result.
- FSM states: IDLE, MUL, ACC, DONE.
- IDLE:
  - in_ready = ~acc_clr.
  - acc_clr=1: acc, exp and sat are cleared; no beat is accepted that cycle.
  - in_valid & in_ready at edge E: capture x_ext (IN_W+1 bits), w and last; clear P, set digit index d=0; go to MUL.
  - acc_clr is ignored in every state except IDLE.
- MUL (ND cycles, edges E+1..E+ND):
  - Digit d is built from {w[2d+1], w[2d], w[2d−1]}, with w[−1]=0.
  - Digit encoding: 000/111→0, 001/010→+1, 011→+2, 100→−2, 101/110→−1.
  - Each cycle: P += (digit·x_ext) << 2d, in (IN_W+1+W_W)-bit two's complement, exact.
  - After digit ND−1, go to ACC.
- ACC (edge E+ND+1):
  - al = P >>> exp (arithmetic shift, floor), sign-extended to ACC_W+1 bits; s = acc + al.
  - If s fits ACC_W signed: acc=s.
  - Else if exp<EXP_MAX: acc = s[ACC_W:1] (arithmetic halve, floor); exp=exp+1.
  - Else: acc = +2^(ACC_W−1)−1 if s>0, otherwise −2^(ACC_W−1); sat=1.
  - While sat=1, further sums are clamped to the same range.
  - Next state: DONE if last, else IDLE.
- Throughput: one beat per ND+2 cycles; in_ready is low in MUL, ACC and DONE.
- DONE:
  - out_valid=1. out_acc, out_exp and out_sat are held stable until out_valid & out_ready.
  - On the handshake edge: acc, exp and sat clear to 0; go to IDLE.
- Outputs out_acc/out_exp/out_sat always reflect the registers and are qualified only by out_valid.
- Exponent never decrements within an epoch; truncated LSBs are lost.

Test Plan (IN_W=4, W_W=4, ACC_W=12, EXP_W=3 unless stated):
1. in_signed=0, x=5, w=3, last=1, accepted at edge E → out_valid from E+3; out_acc=15, out_exp=0, out_sat=0; in_ready=0 during E+1..handshake.
2. in_signed=1, x=4'b1000 (−8), w=4'b1000 (−8), last=1 → out_acc=64. Then in_signed=0, x=4'b1000 (8), w=−8 → out_acc=−64 (12'hFC0).
3. Overflow: 20 beats of x=15 unsigned, w=7 (product 105).
   - After 19 beats acc=1995; the 20th sum is 2100 → acc=1050, exp=1.
   - A 21st beat with last=1 adds 105>>>1=52 → out_acc=1102, out_exp=1, out_sat=0.
4. Saturation with EXP_W=1: the same stream continues until a second overflow → acc=2047, exp=1, sat=1. A following beat with w=−8, x=15 gives 2047−60=1987, out_sat stays 1. Repeat negative-going → clamp at −2048.
5. Backpressure:
   - Hold out_ready=0 for 5 cycles in DONE while toggling in_valid → out_valid stays 1, outputs are stable, no beat is accepted.
   - Raise out_ready → one handshake; the next epoch with x=1, w=1 yields out_acc=1, out_exp=0.
6. Reset and clear:
   - Assert rst in the second MUL cycle → next cycle state=IDLE, acc=0, out_valid=0.
   - In IDLE with acc=40, assert acc_clr together with in_valid → beat not accepted (in_ready=0), acc=0; the beat is accepted on the following cycle.

Source files
------------

// File: rtl/daa_mac_pe.sv
// Neuron processing element: radix-4 Booth serial multiply feeding an accumulator
// that halves itself and bumps a shared exponent on overflow, saturating once the exponent runs out.
//   state | meaning
//   IDLE  | waiting for a beat; acc_clr honoured here only
//   MUL   | one Booth digit per cycle into product register p
//   ACC   | align p by exp and add into acc (rescale or clamp on overflow)
//   DONE  | epoch result presented until out_ready
module daa_mac_pe #(
  parameter int IN_W  = 4,
  parameter int W_W   = 4,
  parameter int ACC_W = 12,
  parameter int EXP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_x,
  input  logic             in_signed,
  input  logic [W_W-1:0]   in_w,
  input  logic             in_last,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sat,
  output logic             busy
);

  localparam int ND = W_W / 2;
  localparam int PW = IN_W + 1 + W_W;
  localparam int DW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

  state_t           state;
  logic [IN_W:0]    x_ext;
  logic [W_W-1:0]   w_q;
  logic             last_q;
  logic [PW-1:0]    p;
  logic [DW-1:0]    d;
  logic [ACC_W-1:0] acc;
  logic [EXP_W-1:0] exp_q;
  logic             sat;

  logic [W_W:0]     w_pad;
  logic [2:0]       trip;
  logic [PW-1:0]    xf;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    pp_sh;
  logic [PW-1:0]    p_sh;
  logic [ACC_W:0]   al;
  logic [ACC_W:0]   s;
  logic             fits;

  assign w_pad = {w_q, 1'b0};

  always_comb begin
    trip = '0;
    for (int i = 0; i < ND; i++) begin
      if (d == DW'(i)) trip = w_pad[2*i +: 3];
    end
  end

  assign xf = {{W_W{x_ext[IN_W]}}, x_ext};

  always_comb begin
    pp = '0;
    case (trip)
      3'b001, 3'b010: pp = xf;
      3'b011:         pp = xf << 1;
      3'b100:         pp = -(xf << 1);
      3'b101, 3'b110: pp = -xf;
      default:        pp = '0;
    endcase
  end

  assign pp_sh = pp << {d, 1'b0};

  // Alignment floors toward minus infinity; the dropped LSBs are gone for good.
  assign p_sh = $signed(p) >>> exp_q;
  assign al   = {{(ACC_W+1-PW){p_sh[PW-1]}}, p_sh};
  assign s    = {acc[ACC_W-1], acc} + al;
  assign fits = (s[ACC_W] == s[ACC_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      x_ext  <= '0;
      w_q    <= '0;
      last_q <= 1'b0;
      p      <= '0;
      d      <= '0;
      acc    <= '0;
      exp_q  <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_clr) begin
            acc   <= '0;
            exp_q <= '0;
            sat   <= 1'b0;
          end else if (in_valid) begin
            x_ext  <= in_signed ? {in_x[IN_W-1], in_x} : {1'b0, in_x};
            w_q    <= in_w;
            last_q <= in_last;
            p      <= '0;
            d      <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          p <= p + pp_sh;
          if (d == DW'(ND - 1)) state <= ACC;
          else                  d     <= d + 1'b1;
        end
        ACC: begin
          if (fits) begin
            acc <= s[ACC_W-1:0];
          end else if (exp_q != EXP_MAX) begin
            acc   <= s[ACC_W:1];
            exp_q <= exp_q + 1'b1;
          end else begin
            acc <= s[ACC_W] ? ACC_MIN : ACC_MAX;
            sat <= 1'b1;
          end
          state <= last_q ? DONE : IDLE;
        end
        DONE: begin
          if (out_ready) begin
            acc   <= '0;
            exp_q <= '0;
            sat   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = ~rst & (state == IDLE) & ~acc_clr;
  assign out_valid = ~rst & (state == DONE);
  assign busy      = ~rst & (state != IDLE);
  assign out_acc   = acc;
  assign out_exp   = exp_q;
  assign out_sat   = sat;

endmodule

// File: tb/tb_daa_mac_pe.sv
// Directed bench for daa_mac_pe: unit 0 uses EXP_W=3, unit 1 uses EXP_W=1 for the saturation path.
module tb_daa_mac_pe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, in_valid, in_signed, in_last, acc_clr, out_ready;
  logic [1:0][3:0]  in_x, in_w;
  wire  [1:0]       in_ready, out_valid, out_sat, busy;
  wire  [1:0][11:0] out_acc;
  wire  [2:0]       out_exp0;
  wire  [0:0]       out_exp1;

  int n_tests = 0;
  int n_fail  = 0;

  daa_mac_pe #(.IN_W(4), .W_W(4), .ACC_W(12), .EXP_W(3)) u_pe0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_x(in_x[0]), .in_signed(in_signed[0]), .in_w(in_w[0]), .in_last(in_last[0]),
    .acc_clr(acc_clr[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_acc(out_acc[0]), .out_exp(out_exp0), .out_sat(out_sat[0]), .busy(busy[0])
  );

  daa_mac_pe #(.IN_W(4), .W_W(4), .ACC_W(12), .EXP_W(1)) u_pe1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_x(in_x[1]), .in_signed(in_signed[1]), .in_w(in_w[1]), .in_last(in_last[1]),
    .acc_clr(acc_clr[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_acc(out_acc[1]), .out_exp(out_exp1), .out_sat(out_sat[1]), .busy(busy[1])
  );

  typedef struct {
    bit         sg;
    logic [3:0] x;
    logic [3:0] w;
    bit         last;
    int         acc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int acc_of(input int u);
    return int'($signed(out_acc[u]));
  endfunction

  function automatic int exp_of(input int u);
    return (u == 0) ? int'(out_exp0) : int'(out_exp1);
  endfunction

  task automatic check_out(input int u, input string name, input int a, input int e, input int s);
    check({name, "_acc"}, acc_of(u), a);
    check({name, "_exp"}, exp_of(u), e);
    check({name, "_sat"}, int'(out_sat[u]), s);
  endtask

  task automatic send_beat(input int u, input bit sg, input logic [3:0] x,
                           input logic [3:0] w, input bit last);
    int guard = 0;
    @(negedge clk);
    while (!in_ready[u] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready[u]) check("beat_ready_timeout", int'(in_ready[u]), 1);
    in_valid[u]  = 1'b1;
    in_signed[u] = sg;
    in_x[u]      = x;
    in_w[u]      = w;
    in_last[u]   = last;
    @(negedge clk);
    in_valid[u] = 1'b0;
    check("busy_mul", int'(busy[u]), 1);
    check("in_ready_mul", int'(in_ready[u]), 0);
    repeat (2) begin
      @(negedge clk);
      check("in_ready_busy", int'(in_ready[u]), 0);
    end
    @(negedge clk);
    check("out_valid_after_beat", int'(out_valid[u]), int'(last));
  endtask

  task automatic handshake(input int u);
    check("hs_out_valid_pre", int'(out_valid[u]), 1);
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    check("hs_out_valid_post", int'(out_valid[u]), 0);
    check_out(u, "hs_clear", 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{sg: 1'b0, x: 4'd5,  w: 4'd3,  last: 1'b1, acc: 15};
    vecs[1] = '{sg: 1'b1, x: 4'h8,  w: 4'h8,  last: 1'b1, acc: 64};
    vecs[2] = '{sg: 1'b0, x: 4'h8,  w: 4'h8,  last: 1'b1, acc: -64};
    vecs[3] = '{sg: 1'b1, x: 4'hF,  w: 4'h7,  last: 1'b0, acc: -7};
    vecs[4] = '{sg: 1'b1, x: 4'h7,  w: 4'h9,  last: 1'b1, acc: -56};
    vecs[5] = '{sg: 1'b0, x: 4'hF,  w: 4'h8,  last: 1'b1, acc: -120};
    vecs[6] = '{sg: 1'b1, x: 4'h8,  w: 4'h7,  last: 1'b1, acc: -56};

    rst = 2'b11; in_valid = '0; in_signed = '0; in_last = '0; acc_clr = '0; out_ready = '0;
    in_x = '0; in_w = '0;

    // Reset state
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_in_ready", int'(in_ready[u]), 0);
      check("rst_out_valid", int'(out_valid[u]), 0);
      check("rst_busy", int'(busy[u]), 0);
    end
    rst = 2'b00;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_out(u, "post_rst", 0, 0, 0);
      check("post_rst_in_ready", int'(in_ready[u]), 1);
    end

    // Table-driven single-epoch products
    for (int i = 0; i < 7; i++) begin
      send_beat(0, vecs[i].sg, vecs[i].x, vecs[i].w, vecs[i].last);
      check_out(0, $sformatf("vec%0d", i), vecs[i].acc, 0, 0);
      if (vecs[i].last) handshake(0);
    end

    // Overflow rescale: 20 x 105 crosses 2047
    for (int i = 0; i < 19; i++) send_beat(0, 1'b0, 4'd15, 4'd7, 1'b0);
    check_out(0, "ovf_19", 1995, 0, 0);
    send_beat(0, 1'b0, 4'd15, 4'd7, 1'b0);
    check_out(0, "ovf_20", 1050, 1, 0);
    send_beat(0, 1'b0, 4'd15, 4'd7, 1'b1);
    check_out(0, "ovf_21", 1102, 1, 0);
    handshake(0);

    // Saturation with a 1-bit exponent
    for (int i = 0; i < 20; i++) send_beat(1, 1'b0, 4'd15, 4'd7, 1'b0);
    check_out(1, "sat_20", 1050, 1, 0);
    for (int i = 0; i < 19; i++) send_beat(1, 1'b0, 4'd15, 4'd7, 1'b0);
    check_out(1, "sat_39", 2038, 1, 0);
    send_beat(1, 1'b0, 4'd15, 4'd7, 1'b0);
    check_out(1, "sat_pos_clamp", 2047, 1, 1);
    send_beat(1, 1'b0, 4'd15, 4'h8, 1'b0);
    check_out(1, "sat_sticky", 1987, 1, 1);
    for (int i = 0; i < 67; i++) send_beat(1, 1'b0, 4'd15, 4'h8, 1'b0);
    check_out(1, "sat_neg_near", -2033, 1, 1);
    send_beat(1, 1'b0, 4'd15, 4'h8, 1'b0);
    check_out(1, "sat_neg_clamp", -2048, 1, 1);
    send_beat(1, 1'b0, 4'd0, 4'd0, 1'b1);
    check_out(1, "sat_epoch_end", -2048, 1, 1);
    handshake(1);

    // Backpressure in DONE
    send_beat(0, 1'b0, 4'd3, 4'd2, 1'b1);
    check_out(0, "bp_result", 6, 0, 0);
    in_x[0] = 4'd1; in_w[0] = 4'd1; in_last[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = ~in_valid[0];
      @(negedge clk);
      check("bp_out_valid", int'(out_valid[0]), 1);
      check("bp_in_ready", int'(in_ready[0]), 0);
      check_out(0, "bp_hold", 6, 0, 0);
    end
    in_valid[0] = 1'b0;
    handshake(0);
    check("bp_idle_busy", int'(busy[0]), 0);
    send_beat(0, 1'b0, 4'd1, 4'd1, 1'b1);
    check_out(0, "bp_next", 1, 0, 0);
    handshake(0);

    // Reset during the second MUL cycle
    send_beat(0, 1'b0, 4'd5, 4'd3, 1'b0);
    check_out(0, "mid_pre", 15, 0, 0);
    in_valid[0] = 1'b1; in_signed[0] = 1'b0; in_x[0] = 4'd7; in_w[0] = 4'd7; in_last[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("mid_busy", int'(busy[0]), 1);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", int'(in_ready[0]), 0);
    check("mid_rst_out_valid", int'(out_valid[0]), 0);
    rst[0] = 1'b0;
    @(negedge clk);
    check("mid_busy_after", int'(busy[0]), 0);
    check("mid_out_valid_after", int'(out_valid[0]), 0);
    check_out(0, "mid_after", 0, 0, 0);
    repeat (3) @(negedge clk);
    check("mid_no_result", int'(out_valid[0]), 0);

    // acc_clr wins over a beat in IDLE
    send_beat(0, 1'b0, 4'd10, 4'd4, 1'b0);
    check_out(0, "clr_pre", 40, 0, 0);
    in_valid[0] = 1'b1; acc_clr[0] = 1'b1; in_signed[0] = 1'b0;
    in_x[0] = 4'd1; in_w[0] = 4'd1; in_last[0] = 1'b1;
    #1;
    check("clr_in_ready", int'(in_ready[0]), 0);
    @(negedge clk);
    acc_clr[0] = 1'b0;
    #1;
    check("clr_busy", int'(busy[0]), 0);
    check_out(0, "clr_post", 0, 0, 0);
    check("clr_in_ready_next", int'(in_ready[0]), 1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("clr_accepted", int'(busy[0]), 1);
    repeat (3) @(negedge clk);
    check("clr_out_valid", int'(out_valid[0]), 1);
    check_out(0, "clr_result", 1, 0, 0);
    handshake(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
